mips_mc_ctrl: RTL and testbench
===============================

Name: mips_mc_ctrl

Overview:
Multi-cycle successor to the single-cycle MIPS main/ALU control decoder. It is a registered FSM that sequences each instruction through fetch, decode, execute, memory and writeback. It drives datapath enables and mux selects, and handshakes with a variable-latency unified memory. It sits between the instruction register (op/funct inputs) and the shared multi-cycle datapath. It adds a memory watchdog and a retired-instruction counter.

Parameters:
OP_W, 6, opcode field width
FUNCT_W, 6, funct field width
CNT_W, 32, width of retired-instruction counter
TIMEOUT, 16, max cycles waiting on mem_ready before bus_err; 0 disables watchdog

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high
op  in  OP_W  opcode from instruction register (valid from DECODE onward)
funct  in  FUNCT_W  funct field from instruction register
mem_ready  in  1  memory completes current read/write this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero (beq)
iord  out  1  memory address select: 0=PC, 1=ALUOut
mem_read  out  1  memory read request, held until mem_ready
mem_write  out  1  memory write request, held until mem_ready
ir_write  out  1  instruction register load
reg_dst  out  2  0=rt, 1=rd, 2=r31
mem_to_reg  out  2  0=ALUOut, 1=MDR, 2=PC (link), 3=shifter
reg_write  out  1  register file write enable
alu_src_a  out  1  0=PC, 1=rs
alu_src_b  out  2  0=rt, 1=const 4, 2=sign-ext imm, 3=imm<<2
pc_source  out  2  0=ALU result, 1=ALUOut, 2=jump target, 3=rs (jr)
alu_control  out  4  add 0010, sub 0110, and 0000, or 0001, slt 0111, sll 1110
bus_err  out  1  sticky watchdog error
illegal_op  out  1  sticky illegal-opcode flag (feature only, else tied 0)
instr_retired  out  CNT_W  count of completed instructions

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high. The ports are named clk and reset. While reset is high, every output is 0, state goes to FETCH, the watchdog counter clears, bus_err/illegal_op clear and instr_retired = 0. Reset mid-instruction abandons it with no write strobe.
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, WB_R, WB_I, BRANCH, JUMP, JAL, JR, HALT.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_control=add. ir_write and pc_write pulse only in the cycle mem_ready=1, then go to DECODE. Otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=3, add (branch target into ALUOut). Dispatch on op:
  - 0 with funct 8 -> JR; other op 0 -> EXEC_R
  - 8 (addi) and 13 (ori) -> EXEC_I
  - 35 (lw) and 43 (sw) -> MEM_ADDR
  - 4 -> BRANCH
  - 2 -> JUMP
  - 3 -> JAL
  - anything else -> FETCH (NOP, retired)
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_control from funct (32 add, 34 sub, 36 and, 37 or, 42 slt, 0 sll). Unknown funct gives add. Next state WB_R.
- WB_R: reg_dst=1, reg_write=1, mem_to_reg=3 if funct==0, else 0.
- EXEC_I: alu_src_a=1, alu_src_b=2, add for addi, or for ori. Next WB_I (reg_dst=0, reg_write=1).
- MEM_ADDR: alu_src_a=1, alu_src_b=2, add. lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: mem_read=1, iord=1. Wait for mem_ready, then MEM_WB (reg_dst=0, mem_to_reg=1, reg_write=1).
- MEM_WR: mem_write=1, iord=1. Leave on mem_ready.
- BRANCH: alu_src_a=1, alu_src_b=0, sub, pc_write_cond=1, pc_source=1.
- JUMP: pc_write=1, pc_source=2.
- JAL: as JUMP plus reg_dst=2, mem_to_reg=2, reg_write=1.
- JR: pc_write=1, pc_source=3.
- All single-cycle terminal states return to FETCH.
- Retirement: instr_retired increments by 1 in the last cycle of each instruction: WB_R, WB_I, MEM_WB, MEM_WR on mem_ready, BRANCH, JUMP, JAL, JR, and DECODE-NOP. It wraps modulo 2^CNT_W.
- Watchdog: counter runs while in FETCH/MEM_RD/MEM_WR with mem_ready=0 and clears on mem_ready or state exit. If it reaches TIMEOUT: bus_err<=1, go to HALT.
- HALT: all strobes 0; leave only by reset.
- mem_ready outside a memory state is ignored.

Optional Feature:
MIPS_MC_ILLEGAL_TRAP_EN:
- Defined: an undecoded opcode in DECODE sets illegal_op (sticky), goes to HALT and is not retired.
- Undefined: an undecoded opcode is a retired NOP and illegal_op is constant 0.

Decomposition:
- Package mips_mc_pkg: state enum; opcode constants (R=0, J=2, JAL=3, BEQ=4, ADDI=8, ORI=13, LW=35, SW=43); funct constants; ALU control codes; mux-select encodings.
- Sub-module mips_mc_alu_dec: combinational funct/op -> alu_control.

Test Plan:
- Reset asserted mid-MEM_WR -> next cycle all outputs 0, instr_retired=0, state FETCH.
- add (op 0, funct 32), mem_ready on first FETCH cycle -> 4 cycles, WB_R asserts reg_dst=1, reg_write=1, alu_control 0010 earlier in EXEC_R; count +1.
- lw with mem_ready delayed 3 cycles in MEM_RD -> mem_read held 4 cycles, iord=1, then MEM_WB mem_to_reg=1; total 5+3 cycles.
- jal -> JAL cycle: pc_write=1, pc_source=2, reg_dst=2, mem_to_reg=2, reg_write=1.
- mem_ready held 0 in FETCH with TIMEOUT=16 -> bus_err=1 after 16 cycles, HALT, no further strobes until reset.
- op=63 -> with macro: illegal_op=1, HALT, count unchanged; without: return to FETCH, count +1.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StExecR,
    StExecI,
    StMemAddr,
    StMemRd,
    StMemWb,
    StMemWr,
    StWbR,
    StWbI,
    StBranch,
    StJump,
    StJal,
    StJr,
    StHalt
  } state_e;

  // How the ALU decoder should derive alu_control in the current state.
  typedef enum logic [2:0] {
    AluOpNone,
    AluOpAdd,
    AluOpSub,
    AluOpFunct,
    AluOpImm
  } alu_op_e;

  localparam logic [5:0] OpR    = 6'd0;
  localparam logic [5:0] OpJ    = 6'd2;
  localparam logic [5:0] OpJal  = 6'd3;
  localparam logic [5:0] OpBeq  = 6'd4;
  localparam logic [5:0] OpAddi = 6'd8;
  localparam logic [5:0] OpOri  = 6'd13;
  localparam logic [5:0] OpLw   = 6'd35;
  localparam logic [5:0] OpSw   = 6'd43;

  localparam logic [5:0] FnSll = 6'd0;
  localparam logic [5:0] FnJr  = 6'd8;
  localparam logic [5:0] FnAdd = 6'd32;
  localparam logic [5:0] FnSub = 6'd34;
  localparam logic [5:0] FnAnd = 6'd36;
  localparam logic [5:0] FnOr  = 6'd37;
  localparam logic [5:0] FnSlt = 6'd42;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluSll = 4'b1110;

  localparam logic [1:0] RegDstRt = 2'd0;
  localparam logic [1:0] RegDstRd = 2'd1;
  localparam logic [1:0] RegDstRa = 2'd2;

  localparam logic [1:0] MemToRegAlu   = 2'd0;
  localparam logic [1:0] MemToRegMdr   = 2'd1;
  localparam logic [1:0] MemToRegPc    = 2'd2;
  localparam logic [1:0] MemToRegShift = 2'd3;

  localparam logic [1:0] SrcBReg   = 2'd0;
  localparam logic [1:0] SrcBFour  = 2'd1;
  localparam logic [1:0] SrcBImm   = 2'd2;
  localparam logic [1:0] SrcBImmSh = 2'd3;

  localparam logic [1:0] PcSrcAlu    = 2'd0;
  localparam logic [1:0] PcSrcAluOut = 2'd1;
  localparam logic [1:0] PcSrcJump   = 2'd2;
  localparam logic [1:0] PcSrcRs     = 2'd3;

endpackage

// File: rtl/mips_mc_alu_dec.sv
// Combinational ALU control decode from the controller's ALU mode, opcode and funct.
module mips_mc_alu_dec
  import mips_mc_pkg::*;
#(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned FUNCT_W = 6
) (
  input  alu_op_e            alu_op,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  output logic [3:0]         alu_control
);

  always_comb begin
    alu_control = AluAnd;
    unique case (alu_op)
      AluOpAdd: alu_control = AluAdd;
      AluOpSub: alu_control = AluSub;
      AluOpFunct: begin
        case (funct)
          FUNCT_W'(FnAdd): alu_control = AluAdd;
          FUNCT_W'(FnSub): alu_control = AluSub;
          FUNCT_W'(FnAnd): alu_control = AluAnd;
          FUNCT_W'(FnOr):  alu_control = AluOr;
          FUNCT_W'(FnSlt): alu_control = AluSlt;
          FUNCT_W'(FnSll): alu_control = AluSll;
          default:         alu_control = AluAdd;
        endcase
      end
      AluOpImm: alu_control = (op == OP_W'(OpOri)) ? AluOr : AluAdd;
      default:  alu_control = AluAnd;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM with memory watchdog and retired-instruction counter.
// Define MIPS_MC_ILLEGAL_TRAP_EN to trap undecoded opcodes into HALT with illegal_op set.
module mips_mc_ctrl
  import mips_mc_pkg::*;
#(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic [3:0]         alu_control,
  output logic               bus_err,
  output logic               illegal_op,
  output logic [CNT_W-1:0]   instr_retired
);

  localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_e           state_q, state_d;
  logic [WdW-1:0]   wd_q, wd_d;
  logic             bus_err_q, bus_err_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;
  logic             wait_mem;
  alu_op_e          alu_op;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      wd_q      <= '0;
      bus_err_q <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      bus_err_q <= bus_err_d;
      illegal_q <= illegal_d;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    wd_d          = '0;
    bus_err_d     = bus_err_q;
    illegal_d     = illegal_q;
    retire        = 1'b0;
    wait_mem      = 1'b0;
    alu_op        = AluOpNone;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = RegDstRt;
    mem_to_reg    = MemToRegAlu;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SrcBReg;
    pc_source     = PcSrcAlu;

    // Outputs are forced low for the whole reset cycle, even mid-instruction.
    if (!reset) begin
      unique case (state_q)
        StFetch: begin
          wait_mem  = 1'b1;
          mem_read  = 1'b1;
          alu_src_b = SrcBFour;
          alu_op    = AluOpAdd;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = StDecode;
          end
        end
        StDecode: begin
          alu_src_b = SrcBImmSh;
          alu_op    = AluOpAdd;
          if (op == OP_W'(OpR)) begin
            state_d = (funct == FUNCT_W'(FnJr)) ? StJr : StExecR;
          end else if (op == OP_W'(OpAddi) || op == OP_W'(OpOri)) begin
            state_d = StExecI;
          end else if (op == OP_W'(OpLw) || op == OP_W'(OpSw)) begin
            state_d = StMemAddr;
          end else if (op == OP_W'(OpBeq)) begin
            state_d = StBranch;
          end else if (op == OP_W'(OpJ)) begin
            state_d = StJump;
          end else if (op == OP_W'(OpJal)) begin
            state_d = StJal;
          end else begin
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
            illegal_d = 1'b1;
            state_d   = StHalt;
`else
            retire    = 1'b1;
            state_d   = StFetch;
`endif
          end
        end
        StExecR: begin
          alu_src_a = 1'b1;
          alu_op    = AluOpFunct;
          state_d   = StWbR;
        end
        StWbR: begin
          reg_dst    = RegDstRd;
          reg_write  = 1'b1;
          mem_to_reg = (funct == FUNCT_W'(FnSll)) ? MemToRegShift : MemToRegAlu;
          retire     = 1'b1;
          state_d    = StFetch;
        end
        StExecI: begin
          alu_src_a = 1'b1;
          alu_src_b = SrcBImm;
          alu_op    = AluOpImm;
          state_d   = StWbI;
        end
        StWbI: begin
          reg_write = 1'b1;
          retire    = 1'b1;
          state_d   = StFetch;
        end
        StMemAddr: begin
          alu_src_a = 1'b1;
          alu_src_b = SrcBImm;
          alu_op    = AluOpAdd;
          state_d   = (op == OP_W'(OpSw)) ? StMemWr : StMemRd;
        end
        StMemRd: begin
          wait_mem = 1'b1;
          mem_read = 1'b1;
          iord     = 1'b1;
          if (mem_ready) state_d = StMemWb;
        end
        StMemWb: begin
          mem_to_reg = MemToRegMdr;
          reg_write  = 1'b1;
          retire     = 1'b1;
          state_d    = StFetch;
        end
        StMemWr: begin
          wait_mem  = 1'b1;
          mem_write = 1'b1;
          iord      = 1'b1;
          if (mem_ready) begin
            retire  = 1'b1;
            state_d = StFetch;
          end
        end
        StBranch: begin
          alu_src_a     = 1'b1;
          alu_op        = AluOpSub;
          pc_write_cond = 1'b1;
          pc_source     = PcSrcAluOut;
          retire        = 1'b1;
          state_d       = StFetch;
        end
        StJump: begin
          pc_write  = 1'b1;
          pc_source = PcSrcJump;
          retire    = 1'b1;
          state_d   = StFetch;
        end
        StJal: begin
          pc_write   = 1'b1;
          pc_source  = PcSrcJump;
          reg_dst    = RegDstRa;
          mem_to_reg = MemToRegPc;
          reg_write  = 1'b1;
          retire     = 1'b1;
          state_d    = StFetch;
        end
        StJr: begin
          pc_write  = 1'b1;
          pc_source = PcSrcRs;
          retire    = 1'b1;
          state_d   = StFetch;
        end
        StHalt: state_d = StHalt;
        default: state_d = StHalt;
      endcase

      // wd_q counts consecutive stalled cycles already spent in this memory state.
      if (wait_mem && !mem_ready && TIMEOUT != 0) begin
        if (wd_q == WdW'(TIMEOUT - 1)) begin
          bus_err_d = 1'b1;
          state_d   = StHalt;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
    end
  end

  mips_mc_alu_dec #(
    .OP_W    (OP_W),
    .FUNCT_W (FUNCT_W)
  ) u_alu_dec (
    .alu_op      (alu_op),
    .op          (op),
    .funct       (funct),
    .alu_control (alu_control)
  );

  assign bus_err       = bus_err_q & ~reset;
  assign illegal_op    = illegal_q & ~reset;
  assign instr_retired = reset ? '0 : cnt_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Randomized scoreboard bench: a transaction-level model expands each instruction into
// its expected per-cycle control vectors; a monitor compares them against the DUT.
module tb_mips_mc_ctrl;

  localparam int unsigned CW      = 4;  // narrow counter so wrap-around is exercised
  localparam int unsigned TIMEOUT = 16;

  typedef struct packed {
    logic          pc_write;
    logic          pc_write_cond;
    logic          iord;
    logic          mem_read;
    logic          mem_write;
    logic          ir_write;
    logic [1:0]    reg_dst;
    logic [1:0]    mem_to_reg;
    logic          reg_write;
    logic          alu_src_a;
    logic [1:0]    alu_src_b;
    logic [1:0]    pc_source;
    logic [3:0]    alu_control;
    logic          bus_err;
    logic          illegal_op;
    logic [CW-1:0] cnt;
  } outs_t;

  localparam logic [3:0] A_ADD = 4'b0010;
  localparam logic [3:0] A_SUB = 4'b0110;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    op = '0;
  logic [5:0]    funct = '0;
  logic          mem_ready = 1'b0;
  logic          pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic [1:0]    reg_dst, mem_to_reg, alu_src_b, pc_source;
  logic          reg_write, alu_src_a, bus_err, illegal_op;
  logic [3:0]    alu_control;
  logic [CW-1:0] instr_retired;
  outs_t         act;

  always #5 clk = ~clk;

  mips_mc_ctrl #(
    .OP_W    (6),
    .FUNCT_W (6),
    .CNT_W   (CW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .op            (op),
    .funct         (funct),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_source     (pc_source),
    .alu_control   (alu_control),
    .bus_err       (bus_err),
    .illegal_op    (illegal_op),
    .instr_retired (instr_retired)
  );

  assign act = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst,
                mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source, alu_control,
                bus_err, illegal_op, instr_retired};

  // Model state: architectural effects only.
  logic [CW-1:0] exp_cnt = '0;
  logic          exp_bus = 1'b0;
  logic          exp_ill = 1'b0;
  logic [5:0]    cur_op = '0;
  logic [5:0]    cur_funct = '0;

  outs_t sb_exp[$];
  string sb_name[$];
  int    vectors = 0;
  int    miscompares = 0;

  always @(negedge clk) begin
    if (sb_exp.size() > 0) begin
      outs_t e;
      string n;
      e = sb_exp.pop_front();
      n = sb_name.pop_front();
      vectors++;
      if (act !== e) begin
        miscompares++;
        $display("FAIL %s @%0t: got %h required %h", n, $time, act, e);
      end
    end
  end

  function automatic outs_t base();
    outs_t o = '0;
    o.cnt        = exp_cnt;
    o.bus_err    = exp_bus;
    o.illegal_op = exp_ill;
    return o;
  endfunction

  function automatic logic [3:0] ref_alu(input logic [5:0] f);
    case (f)
      6'd32:   return A_ADD;
      6'd34:   return A_SUB;
      6'd36:   return 4'b0000;
      6'd37:   return 4'b0001;
      6'd42:   return 4'b0111;
      6'd0:    return 4'b1110;
      default: return A_ADD;
    endcase
  endfunction

  function automatic bit decoded(input logic [5:0] o);
    return o inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd8, 6'd13, 6'd35, 6'd43};
  endfunction

  task automatic cyc(input logic rst, input logic rdy, input outs_t e, input string nm);
    @(posedge clk);
    #1;
    reset     = rst;
    mem_ready = rdy;
    op        = cur_op;
    funct     = cur_funct;
    sb_exp.push_back(e);
    sb_name.push_back(nm);
  endtask

  task automatic step(input outs_t o, input string nm, input bit retire);
    cyc(1'b0, 1'($urandom_range(0, 1)), o, nm);
    if (retire) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic do_reset(input int n);
    exp_cnt = '0;
    exp_bus = 1'b0;
    exp_ill = 1'b0;
    for (int i = 0; i < n; i++) cyc(1'b1, 1'($urandom_range(0, 1)), '0, "reset");
  endtask

  task automatic halt_then_reset(input int n);
    for (int i = 0; i < n; i++) begin
      cur_op    = 6'($urandom);
      cur_funct = 6'($urandom);
      step(base(), "halt", 1'b0);
    end
    do_reset(1);
  endtask

  // Stalls `waits` cycles, then completes; a stall run of TIMEOUT cycles ends in HALT.
  task automatic mem_phase(input outs_t o, input outs_t r, input int waits, input string nm,
                           output bit halted);
    halted = 1'b0;
    for (int i = 0; i < waits; i++) begin
      cyc(1'b0, 1'b0, o, nm);
      if (TIMEOUT != 0 && i + 1 == TIMEOUT) begin
        exp_bus = 1'b1;
        halted  = 1'b1;
        return;
      end
    end
    cyc(1'b0, 1'b1, r, nm);
  endtask

  task automatic run_instr(input logic [5:0] iop, input logic [5:0] ifn, input int wf,
                           input int wm, input bit abort);
    outs_t o, r;
    bit    halted;
    cur_op    = iop;
    cur_funct = ifn;

    o = base(); o.mem_read = 1; o.alu_src_b = 2'd1; o.alu_control = A_ADD;
    r = o; r.ir_write = 1; r.pc_write = 1;
    mem_phase(o, r, wf, "fetch", halted);
    if (halted) begin halt_then_reset(3); return; end

    o = base(); o.alu_src_b = 2'd3; o.alu_control = A_ADD;
    if (!decoded(iop)) begin
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
      step(o, "decode_illegal", 1'b0);
      exp_ill = 1'b1;
      halt_then_reset(3);
`else
      step(o, "decode_nop", 1'b1);
`endif
      return;
    end
    step(o, "decode", 1'b0);

    if (iop == 6'd0 && ifn == 6'd8) begin
      o = base(); o.pc_write = 1; o.pc_source = 2'd3;
      step(o, "jr", 1'b1);
    end else if (iop == 6'd0) begin
      o = base(); o.alu_src_a = 1; o.alu_control = ref_alu(ifn);
      step(o, "exec_r", 1'b0);
      o = base(); o.reg_dst = 2'd1; o.reg_write = 1; o.mem_to_reg = (ifn == 6'd0) ? 2'd3 : 2'd0;
      step(o, "wb_r", 1'b1);
    end else if (iop == 6'd8 || iop == 6'd13) begin
      o = base(); o.alu_src_a = 1; o.alu_src_b = 2'd2;
      o.alu_control = (iop == 6'd13) ? 4'b0001 : A_ADD;
      step(o, "exec_i", 1'b0);
      o = base(); o.reg_write = 1;
      step(o, "wb_i", 1'b1);
    end else if (iop == 6'd35 || iop == 6'd43) begin
      o = base(); o.alu_src_a = 1; o.alu_src_b = 2'd2; o.alu_control = A_ADD;
      step(o, "mem_addr", 1'b0);
      o = base(); o.iord = 1;
      if (iop == 6'd35) begin
        o.mem_read = 1;
        mem_phase(o, o, wm, "mem_rd", halted);
        if (halted) begin halt_then_reset(3); return; end
        o = base(); o.mem_to_reg = 2'd1; o.reg_write = 1;
        step(o, "mem_wb", 1'b1);
      end else begin
        o.mem_write = 1;
        if (abort) begin
          cyc(1'b0, 1'b0, o, "mem_wr");
          cyc(1'b0, 1'b0, o, "mem_wr");
          do_reset(1);
          return;
        end
        mem_phase(o, o, wm, "mem_wr", halted);
        if (halted) begin halt_then_reset(3); return; end
        exp_cnt = exp_cnt + 1'b1;
      end
    end else if (iop == 6'd4) begin
      o = base(); o.alu_src_a = 1; o.alu_control = A_SUB; o.pc_write_cond = 1;
      o.pc_source = 2'd1;
      step(o, "branch", 1'b1);
    end else if (iop == 6'd2) begin
      o = base(); o.pc_write = 1; o.pc_source = 2'd2;
      step(o, "jump", 1'b1);
    end else begin
      o = base(); o.pc_write = 1; o.pc_source = 2'd2; o.reg_dst = 2'd2;
      o.mem_to_reg = 2'd2; o.reg_write = 1;
      step(o, "jal", 1'b1);
    end
  endtask

  initial begin
    logic [5:0] ops[8];
    logic [5:0] fns[6];
    ops = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd8, 6'd13, 6'd35, 6'd43};
    fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0};

    do_reset(2);
    // Directed cases.
    run_instr(6'd0, 6'd32, 0, 0, 1'b0);   // add
    run_instr(6'd35, 6'd0, 0, 3, 1'b0);   // lw, 3 stall cycles
    run_instr(6'd3, 6'd0, 1, 0, 1'b0);    // jal
    run_instr(6'd43, 6'd0, 0, 0, 1'b1);   // sw aborted by reset in MEM_WR
    run_instr(6'd0, 6'd0, 0, 0, 1'b0);    // sll
    run_instr(6'd13, 6'd0, 2, 0, 1'b0);   // ori
    run_instr(6'd0, 6'd8, 0, 0, 1'b0);    // jr
    run_instr(6'd4, 6'd0, 0, 0, 1'b0);    // beq
    run_instr(6'd43, 6'd0, 0, 2, 1'b0);   // sw
    run_instr(6'd0, 6'd34, TIMEOUT - 1, 0, 1'b0);  // one stall short of the watchdog
    run_instr(6'd63, 6'd0, 0, 0, 1'b0);   // undecoded opcode
    run_instr(6'd0, 6'd32, TIMEOUT, 0, 1'b0);      // fetch watchdog fires
    run_instr(6'd35, 6'd0, 0, TIMEOUT, 1'b0);      // mem_rd watchdog fires

    for (int n = 0; n < 150; n++) begin
      logic [5:0] iop, ifn;
      int wf, wm, sel;
      sel = int'($urandom_range(0, 9));
      if (sel == 9) begin
        do iop = 6'($urandom); while (decoded(iop));
      end else begin
        iop = ops[$urandom_range(0, 7)];
      end
      ifn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
      wf  = ($urandom_range(0, 19) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 3));
      wm  = ($urandom_range(0, 29) == 0) ? TIMEOUT : int'($urandom_range(0, 3));
      run_instr(iop, ifn, wf, wm, $urandom_range(0, 24) == 0);
    end

    repeat (2) @(posedge clk);
    for (int i = 0; i < 20 && sb_exp.size() > 0; i++) @(posedge clk);
    if (sb_exp.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d vectors left, required 0", sb_exp.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
